// File: rtl/ysyx_22050612_wbu_if.sv
// Writeback bus: EXU results, LSU load responses/issues, scoreboard and register-file write port.
interface ysyx_22050612_wbu_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
);
    logic                       ex_valid;
    logic                       ex_ready;
    logic                       ex_wen;
    logic [ADDR_WIDTH-1:0]      ex_rd;
    logic [DATA_WIDTH-1:0]      ex_data;
    logic                       ld_valid;
    logic [ADDR_WIDTH-1:0]      ld_rd;
    logic [63:0]                ld_rdata;
    logic [1:0]                 ld_size;
    logic                       ld_unsigned;
    logic [2:0]                 ld_offset;
    logic                       ld_issue;
    logic [ADDR_WIDTH-1:0]      ld_issue_rd;
    logic                       ld_issue_ready;
    logic [2**ADDR_WIDTH-1:0]   busy;
    logic                       rf_wen;
    logic [ADDR_WIDTH-1:0]      rf_waddr;
    logic [DATA_WIDTH-1:0]      rf_wdata;
    logic [63:0]                retire_cnt;

    modport master (
        output ex_valid, ex_wen, ex_rd, ex_data,
        output ld_valid, ld_rd, ld_rdata, ld_size, ld_unsigned, ld_offset,
        output ld_issue, ld_issue_rd,
        input  ex_ready, ld_issue_ready, busy, rf_wen, rf_waddr, rf_wdata, retire_cnt
    );

    modport slave (
        input  ex_valid, ex_wen, ex_rd, ex_data,
        input  ld_valid, ld_rd, ld_rdata, ld_size, ld_unsigned, ld_offset,
        input  ld_issue, ld_issue_rd,
        output ex_ready, ld_issue_ready, busy, rf_wen, rf_waddr, rf_wdata, retire_cnt
    );
endinterface

// File: rtl/ysyx_22050612_wbu.sv
// Writeback unit: LSU-priority arbitration, load extract/extend, registered RF write, pending-load scoreboard.
// Define YSYX_22050612_WBU_TRACE_EN to print each register-file write on the falling edge.
module ysyx_22050612_wbu #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ysyx_22050612_wbu_if.slave    wb
);
    localparam int NREG = 2**ADDR_WIDTH;

    logic [NREG-1:0]        r_busy;
    logic [NREG-1:0]        w_busy_next;
    logic                   r_rf_wen;
    logic [ADDR_WIDTH-1:0]  r_rf_waddr;
    logic [DATA_WIDTH-1:0]  r_rf_wdata;
    logic [63:0]            r_retire_cnt;

    logic                   w_ex_ready;
    logic                   w_ex_fire;
    logic                   w_accept;
    logic [63:0]            w_shifted;
    logic [63:0]            w_ld_ext;
    logic                   w_sign;
    logic                   w_wb_wen;
    logic [ADDR_WIDTH-1:0]  w_wb_rd;
    logic [DATA_WIDTH-1:0]  w_wb_data;

    // An EXU write to a register with a load in flight must wait so the load cannot overwrite it later.
    assign w_ex_ready = rst_n & ~wb.ld_valid & (~wb.ex_wen | ~r_busy[wb.ex_rd]);
    assign w_ex_fire  = wb.ex_valid & w_ex_ready;
    assign w_accept   = wb.ld_valid | w_ex_fire;

    assign w_shifted = wb.ld_rdata >> {wb.ld_offset, 3'b000};

    always_comb begin
        w_sign   = 1'b0;
        w_ld_ext = w_shifted;
        case (wb.ld_size)
            2'd0: begin
                w_sign   = ~wb.ld_unsigned & w_shifted[7];
                w_ld_ext = {{56{w_sign}}, w_shifted[7:0]};
            end
            2'd1: begin
                w_sign   = ~wb.ld_unsigned & w_shifted[15];
                w_ld_ext = {{48{w_sign}}, w_shifted[15:0]};
            end
            2'd2: begin
                w_sign   = ~wb.ld_unsigned & w_shifted[31];
                w_ld_ext = {{32{w_sign}}, w_shifted[31:0]};
            end
            default: w_ld_ext = w_shifted;
        endcase
    end

    always_comb begin
        w_wb_wen  = wb.ex_wen & (|wb.ex_rd);
        w_wb_rd   = wb.ex_rd;
        w_wb_data = wb.ex_data;
        if (wb.ld_valid) begin
            w_wb_wen  = |wb.ld_rd;
            w_wb_rd   = wb.ld_rd;
            w_wb_data = w_ld_ext;
        end
    end

    // Set beats clear per bit so a load re-issued in its own response cycle stays pending.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign w_busy_next[gi] = 1'b0;
            end else begin : g_bit
                assign w_busy_next[gi] =
                    (wb.ld_issue && (wb.ld_issue_rd == ADDR_WIDTH'(gi))) ? 1'b1 :
                    (wb.ld_valid && (wb.ld_rd == ADDR_WIDTH'(gi)))       ? 1'b0 :
                    r_busy[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy       <= '0;
            r_rf_wen     <= 1'b0;
            r_rf_waddr   <= '0;
            r_rf_wdata   <= '0;
            r_retire_cnt <= '0;
        end else begin
            r_busy   <= w_busy_next;
            r_rf_wen <= w_accept & w_wb_wen;
            if (w_accept) begin
                r_rf_waddr   <= w_wb_rd;
                r_rf_wdata   <= w_wb_data;
                r_retire_cnt <= r_retire_cnt + 64'd1;
            end
        end
    end

    assign wb.ex_ready       = w_ex_ready;
    assign wb.ld_issue_ready = ~r_busy[wb.ld_issue_rd];
    assign wb.busy           = r_busy;
    assign wb.rf_wen         = r_rf_wen;
    assign wb.rf_waddr       = r_rf_waddr;
    assign wb.rf_wdata       = r_rf_wdata;
    assign wb.retire_cnt     = r_retire_cnt;

`ifdef YSYX_22050612_WBU_TRACE_EN
    always @(negedge clk) begin
        if (r_rf_wen)
            $display("wbu retire=%h rd=%h data=%h", r_retire_cnt, r_rf_waddr, r_rf_wdata);
    end
`endif
endmodule
